// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate vector sequencer and its signature register.
package gate_seq_pkg;

  localparam int VEC_W = 4;
  localparam int OUT_W = 10;
  localparam int SIG_W = 16;

  localparam logic [VEC_W-1:0] LAST_VEC = 4'hF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  // One signature step: rotate left by one, then fold in the zero-extended gate outputs.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [OUT_W-1:0] data);
    return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ {{(SIG_W-OUT_W){1'b0}}, data};
  endfunction

endpackage

// File: rtl/gate_seq_misr.sv
// Signature register that compacts captured gate outputs; used when GATE_SEQ_SIGNATURE_EN is defined.
module gate_seq_misr
  import gate_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] data_in,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_d, sig_q;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = misr_step(sig_q, data_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/gate_vector_sequencer.sv
// Drives built_in_gates with one vector or all 16, waits SETTLE_CYCLES, then captures the outputs.
// Defining GATE_SEQ_SIGNATURE_EN adds the signature port and its compaction register.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [VEC_W-1:0] vec_in,
  input  logic             abort,
  input  logic [OUT_W-1:0] o_bus,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             cap_valid,
  output logic [VEC_W-1:0] cap_vec,
  output logic [OUT_W-1:0] cap_data,
  output logic             done
`ifdef GATE_SEQ_SIGNATURE_EN
  ,
  output logic [SIG_W-1:0] signature
`endif
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_d, state_q;
  logic [VEC_W-1:0] vec_d, vec_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             mode_d, mode_q;
  logic             busy_d, busy_q;
  logic             cap_valid_d, cap_valid_q;
  logic [VEC_W-1:0] cap_vec_d, cap_vec_q;
  logic [OUT_W-1:0] cap_data_d, cap_data_q;
  logic             done_d, done_q;

  // vec_q is both the sequence position and the driven gate inputs, so it is zeroed on exit.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    cap_valid_d = 1'b0;
    cap_vec_d   = cap_vec_q;
    cap_data_d  = cap_data_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          vec_d   = mode ? '0 : vec_in;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          vec_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          cap_valid_d = 1'b1;
          cap_vec_d   = vec_q;
          cap_data_d  = o_bus;
          if (mode_q && (vec_q != LAST_VEC)) begin
            vec_d = vec_q + VEC_W'(1);
            cnt_d = CNT_LOAD;
          end else begin
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        vec_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_vec_q   <= '0;
      cap_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      cap_valid_q <= cap_valid_d;
      cap_vec_q   <= cap_vec_d;
      cap_data_q  <= cap_data_d;
      done_q      <= done_d;
    end
  end

  assign {a, b, c, d} = vec_q;
  assign busy         = busy_q;
  assign cap_valid    = cap_valid_q;
  assign cap_vec      = cap_vec_q;
  assign cap_data     = cap_data_q;
  assign done         = done_q;

`ifdef GATE_SEQ_SIGNATURE_EN
  logic sig_clr, sig_en;

  // Same conditions as an accepted start and a non-aborted capture above.
  assign sig_clr = (state_q == ST_IDLE) && start;
  assign sig_en  = (state_q == ST_SETTLE) && !abort && (cnt_q == '0);

  gate_seq_misr u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (sig_clr),
    .en      (sig_en),
    .data_in (o_bus),
    .sig     (signature)
  );
`endif

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Randomized plus directed bench for gate_vector_sequencer, two instances (settle 2 and settle 1).
module tb_gate_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, mode, abort;
  logic [3:0] vec_in;

  logic       a0, b0, c0, d0, busy0, cv0, done0;
  logic [3:0] cvec0;
  logic [9:0] cdata0, obus0;
  logic       a1, b1, c1, d1, busy1, cv1, done1;
  logic [3:0] cvec1;
  logic [9:0] cdata1, obus1;
`ifdef GATE_SEQ_SIGNATURE_EN
  logic [15:0] sig0, sig1;
`endif

  assign obus0 = {6'b0, a0, b0, c0, d0};
  assign obus1 = {6'b0, a1, b1, c1, d1};

  always #5 clk = ~clk;

  gate_vector_sequencer #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .vec_in(vec_in),
    .abort(abort), .o_bus(obus0), .a(a0), .b(b0), .c(c0), .d(d0),
    .busy(busy0), .cap_valid(cv0), .cap_vec(cvec0), .cap_data(cdata0),
    .done(done0)
`ifdef GATE_SEQ_SIGNATURE_EN
    , .signature(sig0)
`endif
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .vec_in(vec_in),
    .abort(abort), .o_bus(obus1), .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .cap_valid(cv1), .cap_vec(cvec1), .cap_data(cdata1),
    .done(done1)
`ifdef GATE_SEQ_SIGNATURE_EN
    , .signature(sig1)
`endif
  );

  // Reference model: a run is a list of vectors, each held for settle[i] edges before capture.
  int          settle [2] = '{2, 1};
  bit          m_act  [2];
  bit          m_mode [2];
  int          m_age  [2];
  int          m_v    [2];
  logic [3:0]  e_abcd [2];
  logic [3:0]  e_cvec [2];
  logic        e_busy [2];
  logic        e_cv   [2];
  logic        e_done [2];
  logic [9:0]  e_cdata[2];
  logic [15:0] e_sig  [2];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  int cyc = 0;
  int e0_cyc = 0;
  int cap_cnt [2];
  int busy_cnt[2];
  int done_at [2];
  int cap_seq0[$];

  task automatic resetModel(input int i);
    m_act[i]   = 1'b0;
    m_mode[i]  = 1'b0;
    m_age[i]   = 0;
    m_v[i]     = 0;
    e_abcd[i]  = '0;
    e_cvec[i]  = '0;
    e_busy[i]  = 1'b0;
    e_cv[i]    = 1'b0;
    e_done[i]  = 1'b0;
    e_cdata[i] = '0;
    e_sig[i]   = '0;
  endtask

  task automatic stepModel(input int i);
    e_cv[i]   = 1'b0;
    e_done[i] = 1'b0;
    if (!m_act[i]) begin
      if (start) begin
        m_act[i]  = 1'b1;
        m_mode[i] = mode;
        m_v[i]    = mode ? 0 : int'(vec_in);
        m_age[i]  = 0;
        e_abcd[i] = 4'(m_v[i]);
        e_busy[i] = 1'b1;
        e_sig[i]  = '0;
      end
    end else if (abort) begin
      m_act[i]  = 1'b0;
      e_abcd[i] = '0;
      e_busy[i] = 1'b0;
    end else begin
      m_age[i] = m_age[i] + 1;
      if (m_age[i] >= settle[i]) begin
        e_cv[i]    = 1'b1;
        e_cvec[i]  = 4'(m_v[i]);
        e_cdata[i] = {6'b0, 4'(m_v[i])};
        e_sig[i]   = {e_sig[i][14:0], e_sig[i][15]} ^ {6'b0, e_cdata[i]};
        if (m_mode[i] && m_v[i] < 15) begin
          m_v[i]    = m_v[i] + 1;
          m_age[i]  = 0;
          e_abcd[i] = 4'(m_v[i]);
        end else begin
          m_act[i]  = 1'b0;
          e_abcd[i] = '0;
          e_busy[i] = 1'b0;
          e_done[i] = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) resetModel(i);
      else stepModel(i);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic m, input logic [3:0] v, input logic ab);
    @(negedge clk);
    start  = s;
    mode   = m;
    vec_in = v;
    abort  = ab;
  endtask

  task automatic clearCounters();
    e0_cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      cap_cnt[i]  = 0;
      busy_cnt[i] = 0;
      done_at[i]  = -1;
    end
    cap_seq0.delete();
  endtask

  // Start edge E0 is the posedge right after the first negedge; returns at the negedge after E0.
  task automatic pulseStart(input logic m, input logic [3:0] v);
    applyStimulus(1'b1, m, v, 1'b0);
    clearCounters();
    applyStimulus(1'b0, m, v, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cmp_en) begin
      checkOutput("d0_abcd",  {28'b0, a0, b0, c0, d0}, {28'b0, e_abcd[0]});
      checkOutput("d0_busy",  {31'b0, busy0},          {31'b0, e_busy[0]});
      checkOutput("d0_cv",    {31'b0, cv0},            {31'b0, e_cv[0]});
      checkOutput("d0_cvec",  {28'b0, cvec0},          {28'b0, e_cvec[0]});
      checkOutput("d0_cdata", {22'b0, cdata0},         {22'b0, e_cdata[0]});
      checkOutput("d0_done",  {31'b0, done0},          {31'b0, e_done[0]});
      checkOutput("d1_abcd",  {28'b0, a1, b1, c1, d1}, {28'b0, e_abcd[1]});
      checkOutput("d1_busy",  {31'b0, busy1},          {31'b0, e_busy[1]});
      checkOutput("d1_cv",    {31'b0, cv1},            {31'b0, e_cv[1]});
      checkOutput("d1_cvec",  {28'b0, cvec1},          {28'b0, e_cvec[1]});
      checkOutput("d1_cdata", {22'b0, cdata1},         {22'b0, e_cdata[1]});
      checkOutput("d1_done",  {31'b0, done1},          {31'b0, e_done[1]});
`ifdef GATE_SEQ_SIGNATURE_EN
      checkOutput("d0_sig", {16'b0, sig0}, {16'b0, e_sig[0]});
      checkOutput("d1_sig", {16'b0, sig1}, {16'b0, e_sig[1]});
`endif
    end
    if (cv0) begin
      cap_cnt[0]++;
      cap_seq0.push_back(int'(cvec0));
    end
    if (cv1) cap_cnt[1]++;
    if (busy0) busy_cnt[0]++;
    if (busy1) busy_cnt[1]++;
    if (done0) done_at[0] = cyc - e0_cyc;
    if (done1) done_at[1] = cyc - e0_cyc;
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    mode   = 1'b0;
    vec_in = '0;
    abort  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cap_cnt[i]  = 0;
      busy_cnt[i] = 0;
      done_at[i]  = -1;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_outs0", {a0, b0, c0, d0, busy0, cv0, cvec0, cdata0, done0}, 32'h0);
    checkOutput("rst_outs1", {a1, b1, c1, d1, busy1, cv1, cvec1, cdata1, done1}, 32'h0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single vector 1010
    pulseStart(1'b0, 4'b1010);
    checkOutput("t2_abcd_after_e0", {28'b0, a0, b0, c0, d0}, 32'hA);
    repeat (2) @(negedge clk);
    checkOutput("t2_done",  {31'b0, done0}, 32'h1);
    checkOutput("t2_cv",    {31'b0, cv0},   32'h1);
    checkOutput("t2_cvec",  {28'b0, cvec0}, 32'hA);
    checkOutput("t2_cdata", {22'b0, cdata0}, 32'h00A);
    checkOutput("t2_abcd_cleared", {28'b0, a0, b0, c0, d0}, 32'h0);
`ifdef GATE_SEQ_SIGNATURE_EN
    checkOutput("t2_sig", {16'b0, sig0}, 32'h000A);
`endif
    @(negedge clk);
    checkOutput("t2_done_one_cycle", {31'b0, done0}, 32'h0);
    repeat (2) @(negedge clk);

    // Exhaustive run on both instances
    pulseStart(1'b1, 4'h0);
    repeat (40) @(negedge clk);
    checkOutput("t3_caps0",   cap_cnt[0],  32'd16);
    checkOutput("t3_busy0",   busy_cnt[0], 32'd32);
    checkOutput("t3_doneat0", done_at[0],  32'd32);
    checkOutput("t3_last_cvec0", {28'b0, cvec0}, 32'hF);
    checkOutput("t6_caps1",   cap_cnt[1],  32'd16);
    checkOutput("t6_busy1",   busy_cnt[1], 32'd16);
    checkOutput("t6_doneat1", done_at[1],  32'd16);
    checkOutput("t3_seq_len", cap_seq0.size(), 32'd16);
    for (int k = 0; k < cap_seq0.size(); k++) begin
      checkOutput($sformatf("t3_seq%0d", k), cap_seq0[k], k);
    end

    // Abort on the 5th capture edge of the settle-2 instance
    pulseStart(1'b1, 4'h0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t4_busy",  {31'b0, busy0}, 32'h0);
    checkOutput("t4_abcd",  {28'b0, a0, b0, c0, d0}, 32'h0);
    checkOutput("t4_cvec",  {28'b0, cvec0}, 32'h3);
    checkOutput("t4_cv",    {31'b0, cv0},   32'h0);
    checkOutput("t4_done",  {31'b0, done0}, 32'h0);
    repeat (5) @(negedge clk);
    checkOutput("t4_caps0",   cap_cnt[0], 32'd4);
    checkOutput("t4_nodone0", done_at[0], 32'hFFFF_FFFF);

    // Start while busy is ignored; start right after done is accepted
    pulseStart(1'b1, 4'h0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'hC, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'hC, 1'b0);
    repeat (28) @(negedge clk);
    checkOutput("t5_done_at_e0p32", {31'b0, done0}, 32'h1);
    checkOutput("t5_caps0", cap_cnt[0], 32'd16);
    start  = 1'b1;
    mode   = 1'b0;
    vec_in = 4'b0101;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t5_restart_busy", {31'b0, busy0}, 32'h1);
    checkOutput("t5_restart_abcd", {28'b0, a0, b0, c0, d0}, 32'h5);
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-exhaustive at vector 6
    pulseStart(1'b1, 4'h0);
    repeat (12) @(negedge clk);
    checkOutput("t1_vec6", {28'b0, a0, b0, c0, d0}, 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t1_rst_outs0", {a0, b0, c0, d0, busy0, cv0, cvec0, cdata0, done0}, 32'h0);
    checkOutput("t1_rst_outs1", {a1, b1, c1, d1, busy1, cv1, cvec1, cdata1, done1}, 32'h0);
`ifdef GATE_SEQ_SIGNATURE_EN
    checkOutput("t1_rst_sig0", {16'b0, sig0}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized traffic, checked cycle by cycle against the model
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom % 6) == 0, 1'($urandom), 4'($urandom), ($urandom % 25) == 0);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_vector_sequencer.md
# gate_vector_sequencer

Clocked stimulus sequencer for the `built_in_gates` block. It drives the four gate inputs `a`, `b`, `c`, `d` through a single programmed vector or all 16 combinations. It waits a configurable settle time, then captures the ten gate outputs with their vector for logging or checking. It sits between a test/control host and the combinational gate array, replacing hand-timed stimulus.

## Interface
- `SETTLE_CYCLES`, default 2: cycles between applying a vector and sampling outputs; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  1  sampled with `start`; 1 = exhaustive (vectors 0..15), 0 = single vector.
- `vec_in`  in  4  single-mode vector {a,b,c,d}; sampled with `start`.
- `abort`  in  1  synchronous cancel.
- `o_bus`  in  10  gate outputs {o10..o2,o}.
- `a`, `b`, `c`, `d`  out  1 each  registered gate inputs.
- `busy`  out  1  sequence in progress.
- `cap_valid`  out  1  one-cycle capture strobe.
- `cap_vec`  out  4  vector belonging to `cap_data`.
- `cap_data`  out  10  sampled `o_bus`.
- `done`  out  1  one-cycle completion pulse.
- `signature`  out  16  present only with `GATE_SEQ_SIGNATURE_EN`.

## Operation
- States: IDLE, SETTLE.
- **IDLE**
  - `start`=1 at an edge: load vector (0 if `mode`=1, else `vec_in`), drive `{a,b,c,d}`, load settle counter with `SETTLE_CYCLES-1`, go to SETTLE, `busy`<=1.
- **SETTLE**
  - Counter decrements each edge.
  - At the edge where counter==0: capture (`cap_data`<=`o_bus`, `cap_vec`<=current vector, `cap_valid`<=1).
  - After capture, in exhaustive mode with vector<15: vector+1, drive it on `a..d`, reload counter, stay in SETTLE.
  - Otherwise (single mode, or vector==15): final capture. `{a,b,c,d}`<=0, `busy`<=0, `done`<=1, go to IDLE.
- `start` in SETTLE: ignored, not queued.
- `abort` in SETTLE: next edge goes to IDLE. `a..d`<=0, `busy`<=0. No `cap_valid`, no `done` on that edge.
  - Abort wins over a coincident capture.
  - Abort in IDLE has no effect.
- Vector counter is 4 bits. No wrap occurs, because 15 terminates the sequence.
- Reset is asynchronous at any point, including mid-sequence. It returns to IDLE, sets every output to 0 (including `signature`) and discards any in-flight sequence.

## Timing
- `a..d` change at the start edge E0.
- Vector k (k = 0-based position in the sequence) is captured at edge E0+(k+1)·`SETTLE_CYCLES`. The next vector is applied on that same edge.
- Single mode: `cap_valid` and `done` are high in the cycle after edge E0+`SETTLE_CYCLES`.
- Exhaustive mode:
  - 16 `cap_valid` pulses, spaced `SETTLE_CYCLES` apart.
  - `done` coincides with the 16th pulse.
  - `busy` is high for 16·`SETTLE_CYCLES` cycles.
- `cap_vec`/`cap_data` hold their last values until the next capture.
- `cap_valid` and `done` always last exactly one cycle.
- A new `start` is accepted on the edge after the `done` cycle. Zero idle gap is required.

## Configuration
- `GATE_SEQ_SIGNATURE_EN` defined:
  - `signature` is cleared to 0 when `start` is accepted.
  - On each capture, `signature` <= rotl1(`signature`) ^ {6'b0, `o_bus`}.
  - `signature` holds after `done` or abort.
- Undefined: the `signature` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `gate_seq_pkg` holds:
  - state enum (IDLE, SETTLE)
  - `VEC_W`=4, `OUT_W`=10, `SIG_W`=16
  - `LAST_VEC`=4'hF
- Sub-module `gate_seq_misr` holds the signature register (clear, enable, data in). It is instantiated only under the macro.

## Test plan
Bench loops back `o_bus` = {6'b0,a,b,c,d}; `SETTLE_CYCLES`=2.
1. Reset asserted mid-exhaustive run (vector 6) -> all outputs 0 immediately; state IDLE; next `start` runs normally.
2. Single mode, `vec_in`=4'b1010 -> `a..d`=1010 after E0; `cap_valid`, `done` with `cap_vec`=1010 and `cap_data`=10'h00A at E0+2; `a..d`=0 after; `signature`=16'h000A.
3. Exhaustive -> 16 captures, `cap_vec` 0..15 in order, each `cap_data`=`cap_vec`, 2 cycles apart; `done` with `cap_vec`=15; `busy` high 32 cycles.
4. `abort` coincident with the 5th capture edge -> no 5th `cap_valid`, no `done`; `busy`=0 and `a..d`=0 next cycle; `cap_vec` still 3.
5. `start` pulsed while `busy` -> ignored, sequence unchanged; `start` on the cycle after `done` -> accepted, new sequence begins.
6. `SETTLE_CYCLES`=1, exhaustive -> captures on consecutive cycles; `done` 16 cycles after E0.
